// File: rtl/mux_arr_pkg.sv
// Shared types and the select decoder for the pipelined channel mux / OR-reducer.
package mux_arr_pkg;

    typedef enum logic {
        MODE_MUX = 1'b0,
        MODE_OR  = 1'b1
    } mux_mode_e;

    // Widest channel count the decoder supports; callers size-cast down to N_CH.
    localparam int MAX_CH = 64;

    function automatic logic [MAX_CH-1:0] onehot_dec(input int unsigned sel, input int unsigned n);
        logic [MAX_CH-1:0] gate;
        gate = '0;
        if (sel < n && sel < MAX_CH) begin
            gate[sel] = 1'b1;
        end
        return gate;
    endfunction

endpackage

// File: rtl/mux_arr_logic_pipe_and_or.sv
// Combinational AND-OR reducer: ORs together every channel whose gate bit is set.
module and_or_gate_arr #(
    parameter int N_CH = 4,
    parameter int W    = 2
) (
    input  logic [N_CH-1:0]        gate,
    input  logic [N_CH-1:0][W-1:0] data,
    output logic [W-1:0]           y
);

    // NOTE: always_comb targets get a default before any conditional/loop update so no latch is inferred.
    always_comb begin
        y = '0;
        for (int i = 0; i < N_CH; i++) begin
            y = y | (data[i] & {W{gate[i]}});
        end
    end

endmodule

// File: rtl/mux_arr_logic_pipe.sv
// Two-stage valid/ready pipeline: S1 captures data and a gate vector, S2 captures the reduced result.
module mux_arr_logic_pipe
    import mux_arr_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 2,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH-1:0][W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_any,
    output logic                   out_err
);

    logic                   s1_valid_q, s1_valid_d;
    logic [N_CH-1:0][W-1:0] s1_data_q, s1_data_d;
    logic [N_CH-1:0]        s1_gate_q, s1_gate_d;
    logic                   s1_err_q, s1_err_d;
    mux_mode_e              s1_mode_q, s1_mode_d;

    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           out_data_q, out_data_d;
    logic                   out_any_q, out_any_d;
    logic                   out_err_q, out_err_d;

    logic                   s1_ready, s2_ready;
    logic [W-1:0]           reduced;
    mux_mode_e              mode;

    assign mode     = mux_mode_e'(in_mode);
    assign s2_ready = !out_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_gate_d  = s1_gate_q;
        s1_err_d   = s1_err_q;
        s1_mode_d  = s1_mode_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = mode;
                if (mode == MODE_OR) begin
                    s1_gate_d = '1;
                    s1_err_d  = 1'b0;
                end else begin
                    // An out-of-range select decodes to an all-zero gate, forcing a zero result.
                    s1_gate_d = N_CH'(onehot_dec(32'(in_sel), N_CH));
                    s1_err_d  = int'(in_sel) >= N_CH;
                end
            end
        end
    end

    and_or_gate_arr #(
        .N_CH (N_CH),
        .W    (W)
    ) u_and_or (
        .gate (s1_gate_q),
        .data (s1_data_q),
        .y    (reduced)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_any_d   = out_any_q;
        out_err_d   = out_err_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = reduced;
                out_any_d  = |reduced;
                out_err_d  = s1_err_q && (s1_mode_q == MODE_MUX);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_gate_q   <= '0;
            s1_err_q    <= 1'b0;
            s1_mode_q   <= MODE_MUX;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_any_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_gate_q   <= s1_gate_d;
            s1_err_q    <= s1_err_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_any_q   <= out_any_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_any   = out_any_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mux_arr_logic_pipe.sv
// Self-checking bench: a queue-based reference model plus literal expectations for N_CH=4 and N_CH=3.
module tb_mux_arr_logic_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // N_CH = 4 instance
    logic            in_valid4 = 1'b0, in_ready4, in_mode4 = 1'b0;
    logic [3:0][1:0] in_data4 = '0;
    logic [1:0]      in_sel4 = '0;
    logic            out_valid4, out_ready4 = 1'b1, out_any4, out_err4;
    logic [1:0]      out_data4;

    // N_CH = 3 instance
    logic            in_valid3 = 1'b0, in_ready3, in_mode3 = 1'b0;
    logic [2:0][1:0] in_data3 = '0;
    logic [1:0]      in_sel3 = '0;
    logic            out_valid3, out_ready3 = 1'b1, out_any3, out_err3;
    logic [1:0]      out_data3;

    mux_arr_logic_pipe #(.N_CH(4), .W(2)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_sel(in_sel4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_any(out_any4), .out_err(out_err4)
    );

    mux_arr_logic_pipe #(.N_CH(3), .W(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .in_sel(in_sel3), .in_mode(in_mode3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_any(out_any3), .out_err(out_err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result {err, any, data[1:0]} straight from the selection rules.
    function automatic logic [3:0] model(input logic [7:0] data, input int sel, input logic mode, input int n);
        logic [1:0] r;
        logic       err;
        r   = 2'b00;
        err = 1'b0;
        if (mode) begin
            for (int i = 0; i < n; i++) r = r | data[2*i +: 2];
        end else if (sel >= n) begin
            err = 1'b1;
        end else begin
            r = data[2*sel +: 2];
        end
        return {err, |r, r};
    endfunction

    logic [3:0] q4[$], q3[$], log4[$], log3[$];
    int         logc4[$];
    logic       hold4 = 1'b0;
    logic [3:0] held4;

    // Compare process: pops the model queue on each output transfer, checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            q3.delete();
            hold4 = 1'b0;
        end else begin
            if (hold4) check("hold_stable4", {out_err4, out_any4, out_data4}, held4);
            if (out_valid4) begin
                check("no_stale4", q4.size() > 0, 1);
                if (out_ready4 && q4.size() > 0) begin
                    check("model4", {out_err4, out_any4, out_data4}, q4.pop_front());
                    log4.push_back({out_err4, out_any4, out_data4});
                    logc4.push_back(cyc);
                end
            end
            hold4 = out_valid4 && !out_ready4;
            held4 = {out_err4, out_any4, out_data4};
            if (in_valid4 && in_ready4) q4.push_back(model(in_data4, in_sel4, in_mode4, 4));

            if (out_valid3) begin
                check("no_stale3", q3.size() > 0, 1);
                if (out_ready3 && q3.size() > 0) begin
                    check("model3", {out_err3, out_any3, out_data3}, q3.pop_front());
                    log3.push_back({out_err3, out_any3, out_data3});
                end
            end
            if (in_valid3 && in_ready3) q3.push_back(model({2'b00, in_data3}, in_sel3, in_mode3, 3));
        end
    end

    // Present one item to dut4 and return #1 after the edge that accepts it.
    task automatic push4(input logic mode, input logic [1:0] sel, input logic [7:0] data);
        int n;
        in_valid4 = 1'b1;
        in_mode4  = mode;
        in_sel4   = sel;
        in_data4  = data;
        n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push4_accepted", n < 50, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic mode, input logic [1:0] sel, input logic [5:0] data);
        int n;
        in_valid3 = 1'b1;
        in_mode3  = mode;
        in_sel3   = sel;
        in_data3  = data;
        n = 0;
        @(negedge clk);
        while (!in_ready3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push3_accepted", n < 50, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid4 = 1'b0;
        in_valid3 = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] DATA_A = 8'b00_01_10_11;
    localparam logic [5:0] DATA_3 = 6'b01_10_11;

    initial begin
        int base;
        int nlog;

        // Reset state
        #3;
        check("rst_out_valid", out_valid4, 0);
        check("rst_out_data", out_data4, 0);
        check("rst_out_any", out_any4, 0);
        check("rst_out_err", out_err4, 0);
        #19 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready4, 1);

        // 1: MUX sel=1, exact 2-cycle latency
        push4(1'b0, 2'd1, DATA_A);
        in_valid4 = 1'b0;
        @(negedge clk);
        check("t1_not_yet_valid", out_valid4, 0);
        @(negedge clk);
        check("t1_out_valid", out_valid4, 1);
        check("t1_out_data", out_data4, 2'b10);
        check("t1_out_any", out_any4, 1);
        check("t1_out_err", out_err4, 0);
        @(posedge clk);
        #1;

        // 2: OR mode, nonzero and all-zero data
        push4(1'b1, 2'd0, DATA_A);
        push4(1'b1, 2'd2, 8'h00);
        idle(4);
        check("t2_or_data", log4[log4.size()-2], 4'b0111);
        check("t2_or_zero", log4[log4.size()-1], 4'b0000);

        // 3: back-to-back sel 0..3, in_ready held high
        for (int s = 0; s < 4; s++) begin
            in_valid4 = 1'b1;
            in_mode4  = 1'b0;
            in_sel4   = 2'(s);
            in_data4  = DATA_A;
            @(negedge clk);
            check("t3_in_ready", in_ready4, 1);
            @(posedge clk);
            #1;
        end
        idle(5);
        base = log4.size() - 4;
        check("t3_out0", log4[base],   4'b0111);
        check("t3_out1", log4[base+1], 4'b0110);
        check("t3_out2", log4[base+2], 4'b0101);
        check("t3_out3", log4[base+3], 4'b0000);
        check("t3_consecutive", logc4[base+3] - logc4[base], 3);

        // 4: backpressure, 2 items stored, third stalled
        out_ready4 = 1'b0;
        push4(1'b0, 2'd2, DATA_A);
        push4(1'b0, 2'd1, DATA_A);
        in_valid4 = 1'b1;
        in_mode4  = 1'b0;
        in_sel4   = 2'd0;
        in_data4  = DATA_A;
        repeat (3) begin
            @(negedge clk);
            check("t4_in_ready_low", in_ready4, 0);
        end
        @(posedge clk);
        #1;
        out_ready4 = 1'b1;
        push4(1'b0, 2'd0, DATA_A);
        idle(5);
        base = log4.size() - 3;
        check("t4_first", log4[base],   4'b0101);
        check("t4_second", log4[base+1], 4'b0110);
        check("t4_third", log4[base+2], 4'b0111);

        // 5: N_CH=3, out-of-range select then a valid one
        push3(1'b0, 2'd3, DATA_3);
        push3(1'b0, 2'd0, DATA_3);
        idle(5);
        check("t5_err_item", log3[log3.size()-2], 4'b1000);
        check("t5_ok_item", log3[log3.size()-1], 4'b0111);

        // 6: reset with two items in flight
        out_ready4 = 1'b0;
        push4(1'b1, 2'd0, DATA_A);
        push4(1'b0, 2'd3, DATA_A);
        in_valid4 = 1'b0;
        nlog = log4.size();
        #2 rst = 1'b1;
        #1;
        check("t6_valid_async_low", out_valid4, 0);
        check("t6_data_cleared", out_data4, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("t6_in_ready", in_ready4, 1);
        idle(6);
        check("t6_no_stale_output", log4.size(), nlog);

        check("q4_drained", q4.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
